axilite_ip_arbiter: RTL and testbench
=====================================

Name: axilite_ip_arbiter

Overview:
- Shares one IP-side register port (ip_en/ip_wen/ip_addr/ip_wdata/ip_rack/ip_rdata) among N requesters, e.g. several AXI-lite frontends or an on-chip config sequencer plus a host frontend.
- Grants round-robin and keeps at most one read outstanding at a time.
- Routes each read reply back to the requester that issued it.
- Guards against a silent IP with a read timeout that returns an error response.

Parameters:
- N, 2, number of requesters (1..16).
- ADDR_WIDTH, 8, IP word-address width.
- DATA_WIDTH, 32, IP data width.
- TIMEOUT, 256, maximum cycles to wait for ip_rack after ip_en on a read; 0 disables the timeout.

Ports:
- aclk  in  1  clock.
- aresetn  in  1  reset; asynchronous, active-low.
- req_vld  in  N  per-requester command valid.
- req_rdy  out  N  per-requester command accept (one-hot or zero).
- req_wen  in  N  per-requester 1=write, 0=read.
- req_addr  in  N*ADDR_WIDTH  flattened addresses; requester i uses slice [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_wdata  in  N*DATA_WIDTH  flattened write data, sliced the same way.
- rsp_vld  out  N  one-cycle completion pulse per requester.
- rsp_err  out  1  qualifies rsp_vld; 1 = read timed out.
- rsp_rdata  out  DATA_WIDTH  read data, valid with rsp_vld.
- ip_en  out  1  one-cycle command strobe.
- ip_wen  out  1  write qualifier of ip_en.
- ip_addr  out  ADDR_WIDTH  command address.
- ip_wdata  out  DATA_WIDTH  write data.
- ip_rack  in  1  read acknowledge; may arrive in the ip_en cycle or later.
- ip_rdata  in  DATA_WIDTH  read data, valid with ip_rack.

Behaviour:
- Reset (aresetn low, async): state=IDLE, rr pointer=0, timeout counter=0.
  - Registered outputs clear: ip_en=0, ip_wen=0, ip_addr=0, ip_wdata=0, rsp_vld=0, rsp_err=0, rsp_rdata=0.
  - req_rdy is forced to 0 while aresetn is low.
  - Reset mid-read drops the outstanding transaction with no response.
- States: IDLE, RWAIT.
- Grant in IDLE:
  - Winner g = first i with req_vld[i]=1, searching from the rr pointer upward modulo N.
  - req_rdy[g]=1 combinationally in the same cycle; all other req_rdy=0.
  - In RWAIT, req_rdy=0.
  - Handshake occurs when req_vld[g] && req_rdy[g] (cycle t). Requesters must hold command fields stable until accepted.
- On accept at t:
  - rr pointer <= (g+1) mod N.
  - At t+1: ip_en=1, ip_wen=req_wen[g], ip_addr/ip_wdata = slices of g.
  - ip_en lasts exactly one cycle. ip_wen/ip_addr/ip_wdata hold their last values while ip_en=0.
- Writes:
  - rsp_vld[g]=1 and rsp_err=0 at t+1, coincident with ip_en.
  - State stays IDLE, so back-to-back writes sustain one command per cycle.
- Reads:
  - State becomes RWAIT at t+1. The arbiter latches g as the owner and clears the counter.
  - In RWAIT, each cycle with ip_rack=1 (including the ip_en cycle t+1): next cycle rsp_vld[owner]=1, rsp_err=0, rsp_rdata=ip_rdata; state returns to IDLE.
  - New grants are possible in that response cycle, so the minimum read-to-next-command spacing is 2 cycles after ip_rack.
- Timeout (TIMEOUT>0):
  - The counter increments every RWAIT cycle without ip_rack.
  - When the counter reaches TIMEOUT-1 with no ack: next cycle rsp_vld[owner]=1, rsp_err=1, rsp_rdata=0; state returns to IDLE.
  - ip_rack and timeout in the same cycle: the ack wins (err=0).
  - ip_rack received in IDLE (late ack) is ignored and produces no response.
  - TIMEOUT=0 means wait indefinitely.
- Response outputs:
  - rsp_vld is at most one-hot.
  - rsp_rdata = 0 and rsp_err = 0 in cycles with no read response, including write responses.
- Responses cannot be back-pressured; requesters must accept rsp_vld when it is presented.
- A requester with req_vld held high is served again only after all other active requesters (fairness bound N-1 grants).

Test Plan:
- Single write: N=2, req0 write addr 0x05 data 0xDEADBEEF → req_rdy[0] same cycle; next cycle ip_en=1, ip_wen=1, ip_addr=0x05, ip_wdata=0xDEADBEEF, rsp_vld=2'b01, rsp_err=0.
- Round robin: req0 and req1 both assert writes continuously for 4 grants → grant order 0,1,0,1; ip_en high for 4 consecutive cycles.
- Read with latency 3: req1 read addr 0x10; IP raises ip_rack 3 cycles after ip_en with 0x1234 → rsp_vld=2'b10, rsp_rdata=0x1234, rsp_err=0; req_rdy stays 0 throughout RWAIT.
- Zero-latency ack: ip_rack coincident with ip_en, data 0xA5 → response one cycle after ip_en.
- Timeout: TIMEOUT=8, read with no ip_rack → rsp_vld to the owner 8 cycles after ip_en with rsp_err=1, rsp_rdata=0; a late ip_rack 2 cycles later produces no rsp_vld.
- Reset mid-read: assert aresetn low while in RWAIT → ip_en and rsp_vld fall immediately (async); after release no response is issued and the next grant goes to requester 0.

Source files
------------

// File: rtl/axilite_ip_arbiter.sv
// Round-robin arbiter sharing one IP register port among N requesters.
// At most one read is outstanding; replies are routed back to their owner, with an error reply on read timeout.
module axilite_ip_arbiter #(
  parameter int N          = 2,
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 256
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic [N-1:0]            req_vld,
  output logic [N-1:0]            req_rdy,
  input  logic [N-1:0]            req_wen,
  input  logic [N*ADDR_WIDTH-1:0] req_addr,
  input  logic [N*DATA_WIDTH-1:0] req_wdata,
  output logic [N-1:0]            rsp_vld,
  output logic                    rsp_err,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    ip_en,
  output logic                    ip_wen,
  output logic [ADDR_WIDTH-1:0]   ip_addr,
  output logic [DATA_WIDTH-1:0]   ip_wdata,
  input  logic                    ip_rack,
  input  logic [DATA_WIDTH-1:0]   ip_rdata
);

  localparam int PW    = (N > 1) ? $clog2(N) : 1;
  localparam int CW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int TLAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

  typedef enum logic {IDLE, RWAIT} state_t;

  state_t                  state_q, state_d;
  logic [PW-1:0]           rr_q, rr_d;
  logic [PW-1:0]           owner_q, owner_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    ip_en_q, ip_en_d;
  logic                    ip_wen_q, ip_wen_d;
  logic [ADDR_WIDTH-1:0]   ip_addr_q, ip_addr_d;
  logic [DATA_WIDTH-1:0]   ip_wdata_q, ip_wdata_d;
  logic [N-1:0]            rsp_vld_q, rsp_vld_d;
  logic                    rsp_err_q, rsp_err_d;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;

  logic [ADDR_WIDTH-1:0]   addr_arr  [N];
  logic [DATA_WIDTH-1:0]   wdata_arr [N];
  logic [N-1:0]            vld_rot;
  logic                    gnt_found;
  logic [PW-1:0]           gnt_idx;

  for (genvar gi = 0; gi < N; gi++) begin : g_slice
    assign addr_arr[gi]  = req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
    assign wdata_arr[gi] = req_wdata[gi*DATA_WIDTH +: DATA_WIDTH];
  end

  function automatic logic [N-1:0] onehot(input logic [PW-1:0] idx);
    onehot = '0;
    for (int i = 0; i < N; i++) onehot[i] = (PW'(i) == idx);
  endfunction

  // Rotate so bit 0 is the requester at the rr pointer; the lowest set bit wins.
  assign vld_rot = N'({req_vld, req_vld} >> rr_q);

  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int k = 0; k < N; k++) begin
      if (!gnt_found && vld_rot[k]) begin
        gnt_found = 1'b1;
        gnt_idx   = PW'((int'(rr_q) + k) % N);
      end
    end
  end

  always_comb begin
    req_rdy = '0;
    if (aresetn && state_q == IDLE && gnt_found) req_rdy = onehot(gnt_idx);
  end

  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    owner_d     = owner_q;
    cnt_d       = cnt_q;
    ip_en_d     = 1'b0;
    ip_wen_d    = ip_wen_q;
    ip_addr_d   = ip_addr_q;
    ip_wdata_d  = ip_wdata_q;
    rsp_vld_d   = '0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = '0;
    case (state_q)
      IDLE: begin
        if (gnt_found) begin
          ip_en_d    = 1'b1;
          ip_wen_d   = req_wen[gnt_idx];
          ip_addr_d  = addr_arr[gnt_idx];
          ip_wdata_d = wdata_arr[gnt_idx];
          rr_d       = (gnt_idx == PW'(N - 1)) ? '0 : gnt_idx + 1'b1;
          if (req_wen[gnt_idx]) begin
            rsp_vld_d = onehot(gnt_idx);
          end else begin
            state_d = RWAIT;
            owner_d = gnt_idx;
            cnt_d   = '0;
          end
        end
      end
      RWAIT: begin
        // An ack in the same cycle as the timeout takes priority.
        if (ip_rack) begin
          rsp_vld_d   = onehot(owner_q);
          rsp_rdata_d = ip_rdata;
          state_d     = IDLE;
        end else if (TIMEOUT > 0 && cnt_q == CW'(TLAST)) begin
          rsp_vld_d = onehot(owner_q);
          rsp_err_d = 1'b1;
          state_d   = IDLE;
        end else if (TIMEOUT > 0) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= IDLE;
      rr_q        <= '0;
      owner_q     <= '0;
      cnt_q       <= '0;
      ip_en_q     <= 1'b0;
      ip_wen_q    <= 1'b0;
      ip_addr_q   <= '0;
      ip_wdata_q  <= '0;
      rsp_vld_q   <= '0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      owner_q     <= owner_d;
      cnt_q       <= cnt_d;
      ip_en_q     <= ip_en_d;
      ip_wen_q    <= ip_wen_d;
      ip_addr_q   <= ip_addr_d;
      ip_wdata_q  <= ip_wdata_d;
      rsp_vld_q   <= rsp_vld_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign ip_en     = ip_en_q;
  assign ip_wen    = ip_wen_q;
  assign ip_addr   = ip_addr_q;
  assign ip_wdata  = ip_wdata_q;
  assign rsp_vld   = rsp_vld_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_axilite_ip_arbiter.sv
// Self-checking bench for axilite_ip_arbiter (N=2, TIMEOUT=8): directed table and sequences,
// then randomized traffic against a transaction-level reference model.
module tb_axilite_ip_arbiter;

  localparam int N  = 2;
  localparam int AW = 8;
  localparam int DW = 32;
  localparam int TO = 8;

  logic              aclk;
  logic              aresetn;
  logic [N-1:0]      req_vld;
  logic [N-1:0]      req_rdy;
  logic [N-1:0]      req_wen;
  logic [N*AW-1:0]   req_addr;
  logic [N*DW-1:0]   req_wdata;
  logic [N-1:0]      rsp_vld;
  logic              rsp_err;
  logic [DW-1:0]     rsp_rdata;
  logic              ip_en;
  logic              ip_wen;
  logic [AW-1:0]     ip_addr;
  logic [DW-1:0]     ip_wdata;
  logic              ip_rack;
  logic [DW-1:0]     ip_rdata;

  int total = 0;
  int bad   = 0;

  axilite_ip_arbiter #(.N(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .req_vld(req_vld), .req_rdy(req_rdy), .req_wen(req_wen),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_vld(rsp_vld), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
    .ip_en(ip_en), .ip_wen(ip_wen), .ip_addr(ip_addr), .ip_wdata(ip_wdata),
    .ip_rack(ip_rack), .ip_rdata(ip_rdata)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_cmd(input int i, input logic w, input logic [7:0] a, input logic [31:0] d,
                        input logic [1:0] erdy);
    @(negedge aclk);
    ip_rack = 1'b0;
    req_wen[i] = w;
    req_addr[i*AW +: AW] = a;
    req_wdata[i*DW +: DW] = d;
    req_vld = 2'(2'b01 << i);
    #1 check("cmd_rdy", 64'(req_rdy), 64'(erdy));
    @(posedge aclk);
    #1;
    check("cmd_en", 64'(ip_en), 64'(1'b1));
    check("cmd_wen", 64'(ip_wen), 64'(w));
    check("cmd_addr", 64'(ip_addr), 64'(a));
    $display("txn req=%0d %s addr=%02h", i, w ? "wr" : "rd", a);
  endtask

  typedef struct {
    logic [1:0]  vld;
    logic [1:0]  rdy;
    logic        en;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [1:0]  rspv;
  } vec_t;
  vec_t vecs[7];

  // Reference model state
  bit          m_busy;
  int          m_owner, m_en_cyc, m_rr;
  logic        e_en, e_wen, e_err;
  logic [7:0]  e_addr;
  logic [31:0] e_wdata, e_rdata;
  logic [1:0]  e_rspv;
  logic [1:0]  pend, acc, cw;
  logic [7:0]  ca [2];
  logic [31:0] cd [2];

  initial begin
    aresetn = 1'b0; req_vld = 2'b11; req_wen = 2'b11; req_addr = '0; req_wdata = '0;
    ip_rack = 1'b0; ip_rdata = '0;
    vecs[0] = '{2'b01, 2'b01, 1'b1, 8'h05, 32'hDEADBEEF, 2'b01};
    vecs[1] = '{2'b11, 2'b10, 1'b1, 8'h22, 32'h11112222, 2'b10};
    vecs[2] = '{2'b11, 2'b01, 1'b1, 8'h05, 32'hDEADBEEF, 2'b01};
    vecs[3] = '{2'b11, 2'b10, 1'b1, 8'h22, 32'h11112222, 2'b10};
    vecs[4] = '{2'b11, 2'b01, 1'b1, 8'h05, 32'hDEADBEEF, 2'b01};
    vecs[5] = '{2'b00, 2'b00, 1'b0, 8'h05, 32'hDEADBEEF, 2'b00};
    vecs[6] = '{2'b01, 2'b01, 1'b1, 8'h05, 32'hDEADBEEF, 2'b01};

    repeat (3) @(negedge aclk);
    #1;
    check("rst_rdy", 64'(req_rdy), 64'(0));
    check("rst_en", 64'(ip_en), 64'(0));
    check("rst_addr", 64'(ip_addr), 64'(0));
    check("rst_wdata", 64'(ip_wdata), 64'(0));
    check("rst_rspv", 64'(rsp_vld), 64'(0));
    check("rst_rdata", 64'(rsp_rdata), 64'(0));
    @(negedge aclk);
    aresetn = 1'b1; req_vld = 2'b00;

    // Write table: single write, then round robin
    req_wen = 2'b11;
    req_addr = {8'h22, 8'h05};
    req_wdata = {32'h11112222, 32'hDEADBEEF};
    for (int r = 0; r < 7; r++) begin
      @(negedge aclk);
      req_vld = vecs[r].vld;
      #1 check($sformatf("tbl%0d_rdy", r), 64'(req_rdy), 64'(vecs[r].rdy));
      @(posedge aclk);
      #1;
      check($sformatf("tbl%0d_en", r), 64'(ip_en), 64'(vecs[r].en));
      check($sformatf("tbl%0d_wen", r), 64'(ip_wen), 64'(1'b1));
      check($sformatf("tbl%0d_addr", r), 64'(ip_addr), 64'(vecs[r].addr));
      check($sformatf("tbl%0d_wdata", r), 64'(ip_wdata), 64'(vecs[r].wdata));
      check($sformatf("tbl%0d_rspv", r), 64'(rsp_vld), 64'(vecs[r].rspv));
      check($sformatf("tbl%0d_err", r), 64'({rsp_err, rsp_rdata}), 64'(0));
      $display("txn table row=%0d vld=%b rdy=%b", r, vecs[r].vld, req_rdy);
    end

    // Read by req1, ack 3 cycles after ip_en
    do_cmd(1, 1'b0, 8'h10, 32'h0, 2'b10);
    check("rd3_rspv0", 64'(rsp_vld), 64'(0));
    for (int k = 0; k < 4; k++) begin
      @(negedge aclk);
      req_vld = (k < 3) ? 2'b11 : 2'b00;
      req_wen = 2'b11;
      ip_rack = (k == 3);
      ip_rdata = (k == 3) ? 32'h1234 : 32'h5555_0000;
      #1 check("rd3_rwait_rdy", 64'(req_rdy), 64'(0));
      @(posedge aclk);
      #1;
      if (k < 3) begin
        check("rd3_wait_rspv", 64'(rsp_vld), 64'(0));
      end else begin
        check("rd3_rspv", 64'(rsp_vld), 64'(2'b10));
        check("rd3_rdata", 64'(rsp_rdata), 64'(32'h1234));
        check("rd3_err", 64'(rsp_err), 64'(0));
      end
    end

    // Zero-latency ack by req0
    do_cmd(0, 1'b0, 8'h33, 32'h0, 2'b01);
    @(negedge aclk);
    req_vld = 2'b00; ip_rack = 1'b1; ip_rdata = 32'hA5;
    @(posedge aclk);
    #1;
    check("rd0_rspv", 64'(rsp_vld), 64'(2'b01));
    check("rd0_rdata", 64'(rsp_rdata), 64'(32'hA5));
    check("rd0_en", 64'(ip_en), 64'(0));

    // Timeout by req1, then a late ack
    do_cmd(1, 1'b0, 8'h44, 32'h0, 2'b10);
    for (int k = 0; k < TO; k++) begin
      @(negedge aclk);
      req_vld = 2'b00; ip_rack = 1'b0; ip_rdata = 32'hFFFF_FFFF;
      @(posedge aclk);
      #1;
      if (k < TO - 1) begin
        check("to_wait_rspv", 64'(rsp_vld), 64'(0));
      end else begin
        check("to_rspv", 64'(rsp_vld), 64'(2'b10));
        check("to_err", 64'(rsp_err), 64'(1));
        check("to_rdata", 64'(rsp_rdata), 64'(0));
      end
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge aclk);
      ip_rack = (k == 2);
      @(posedge aclk);
      #1 check("late_ack_rspv", 64'({rsp_vld, rsp_err}), 64'(0));
    end

    // Reset while a read is outstanding
    do_cmd(0, 1'b0, 8'h66, 32'h0, 2'b01);
    @(negedge aclk);
    req_vld = 2'b11; req_wen = 2'b11; aresetn = 1'b0;
    #1;
    check("mrst_en", 64'(ip_en), 64'(0));
    check("mrst_rspv", 64'(rsp_vld), 64'(0));
    check("mrst_rdy", 64'(req_rdy), 64'(0));
    check("mrst_addr", 64'(ip_addr), 64'(0));
    repeat (2) @(negedge aclk);
    aresetn = 1'b1; req_vld = 2'b00; ip_rack = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge aclk);
      #1 check("mrst_no_rsp", 64'({rsp_vld, ip_en}), 64'(0));
    end
    @(negedge aclk);
    ip_rack = 1'b0; req_vld = 2'b11;
    #1 check("mrst_next_gnt", 64'(req_rdy), 64'(2'b01));
    @(posedge aclk);
    #1 check("mrst_next_addr", 64'(ip_addr), 64'(8'h66));
    @(negedge aclk);
    req_vld = 2'b00;

    // Randomized traffic against the reference model
    aresetn = 1'b0;
    repeat (2) @(negedge aclk);
    aresetn = 1'b1; ip_rack = 1'b0;
    m_busy = 0; m_owner = 0; m_en_cyc = 0; m_rr = 0;
    e_en = 0; e_wen = 0; e_err = 0; e_addr = '0; e_wdata = '0; e_rdata = '0; e_rspv = '0;
    pend = '0; acc = '0; cw = '0;
    for (int i = 0; i < N; i++) begin ca[i] = '0; cd[i] = '0; end
    for (int c = 0; c < 600; c++) begin
      int w;
      logic [1:0] exp_rdy;
      @(negedge aclk);
      check("r_en", 64'(ip_en), 64'(e_en));
      check("r_wen", 64'(ip_wen), 64'(e_wen));
      check("r_addr", 64'(ip_addr), 64'(e_addr));
      check("r_wdata", 64'(ip_wdata), 64'(e_wdata));
      check("r_rspv", 64'(rsp_vld), 64'(e_rspv));
      check("r_err", 64'(rsp_err), 64'(e_err));
      check("r_rdata", 64'(rsp_rdata), 64'(e_rdata));
      for (int i = 0; i < N; i++) begin
        if (acc[i]) pend[i] = 1'b0;
        if (!pend[i] && $urandom_range(1, 0) == 1) begin
          pend[i] = 1'b1;
          cw[i] = 1'($urandom_range(1, 0));
          ca[i] = 8'($urandom);
          cd[i] = $urandom;
        end
        req_wen[i] = cw[i];
        req_addr[i*AW +: AW] = ca[i];
        req_wdata[i*DW +: DW] = cd[i];
      end
      req_vld = pend;
      ip_rack = ($urandom_range(3, 0) == 0);
      ip_rdata = $urandom;
      #1;
      // Winner: the valid requester closest to the rr pointer going upward.
      w = -1;
      if (!m_busy) begin
        for (int i = 0; i < N; i++) begin
          if (req_vld[i] && (w < 0 || ((i - m_rr + N) % N) < ((w - m_rr + N) % N))) w = i;
        end
      end
      exp_rdy = (w >= 0) ? 2'(1 << w) : 2'b00;
      check("r_rdy", 64'(req_rdy), 64'(exp_rdy));
      acc = exp_rdy;
      e_en = 1'b0; e_rspv = '0; e_err = 1'b0; e_rdata = '0;
      if (m_busy) begin
        if (ip_rack) begin
          e_rspv = 2'(1 << m_owner); e_rdata = ip_rdata; m_busy = 0;
          $display("txn rsp req=%0d data=%08h", m_owner, ip_rdata);
        end else if (c - m_en_cyc == TO - 1) begin
          e_rspv = 2'(1 << m_owner); e_err = 1'b1; m_busy = 0;
          $display("txn rsp req=%0d timeout", m_owner);
        end
      end else if (w >= 0) begin
        e_en = 1'b1; e_wen = cw[w]; e_addr = ca[w]; e_wdata = cd[w];
        m_rr = (w + 1) % N;
        if (cw[w]) begin
          e_rspv = 2'(1 << w);
        end else begin
          m_busy = 1; m_owner = w; m_en_cyc = c + 1;
        end
        $display("txn req=%0d %s addr=%02h", w, cw[w] ? "wr" : "rd", ca[w]);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
